// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice scheduler: free-voice allocation,
// same-key retrigger and oldest-voice stealing with a note-0 retrigger gap.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int STEAL_GAP  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ev_valid,
  output logic                      ev_ready,
  input  logic                      ev_key_on,
  input  logic [4:0]                ev_note,
  input  logic [1:0]                ev_octave,
  input  logic [NUM_VOICES-1:0]     voice_done,
  output logic [5*NUM_VOICES-1:0]   voice_note,
  output logic [2*NUM_VOICES-1:0]   voice_octave,
  output logic [NUM_VOICES-1:0]     voice_busy,
  output logic                      steal_pulse
);

  localparam int IW = $clog2(NUM_VOICES);

  typedef enum logic [1:0] {S_IDLE, S_DECIDE, S_GAP} state_t;

  state_t          state, state_d;
  logic [4:0]      note   [NUM_VOICES];
  logic [1:0]      octave [NUM_VOICES];
  logic [7:0]      age    [NUM_VOICES];

  logic            lat_key_on;
  logic [4:0]      lat_note;
  logic [1:0]      lat_octave;
  logic [3:0]      gap_cnt;
  logic [IW-1:0]   target;

  logic [NUM_VOICES-1:0] busy_now, free, match;
  logic            free_any, match_any, old_any;
  logic [IW-1:0]   free_idx, match_idx, old_idx;
  logic [7:0]      old_age;

  logic            do_write, do_zero, do_clear_match, steal_d;
  logic [IW-1:0]   write_idx, zero_idx;

  always_comb begin
    busy_now = '0;
    free     = '0;
    match    = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      busy_now[i] = (note[i] != 5'd0) || !voice_done[i];
      free[i]     = (note[i] == 5'd0) && voice_done[i];
      match[i]    = (lat_note != 5'd0) && (note[i] == lat_note) && (octave[i] == lat_octave);
    end
  end

  // Descending scan leaves the lowest index selected for free/match.
  always_comb begin
    free_any  = 1'b0;
    free_idx  = '0;
    match_any = 1'b0;
    match_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (free[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
      if (match[i]) begin
        match_any = 1'b1;
        match_idx = IW'(i);
      end
    end
  end

  // Strict greater-than keeps the lowest index on equal ages.
  always_comb begin
    old_any = 1'b0;
    old_idx = '0;
    old_age = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (busy_now[i] && (!old_any || age[i] > old_age)) begin
        old_any = 1'b1;
        old_age = age[i];
        old_idx = IW'(i);
      end
    end
  end

  always_comb begin
    state_d        = state;
    ev_ready       = (state == S_IDLE);
    do_write       = 1'b0;
    do_zero        = 1'b0;
    do_clear_match = 1'b0;
    steal_d        = 1'b0;
    write_idx      = target;
    zero_idx       = '0;
    case (state)
      S_IDLE: begin
        if (ev_valid) state_d = S_DECIDE;
      end
      S_DECIDE: begin
        state_d = S_IDLE;
        if (!lat_key_on) begin
          do_clear_match = 1'b1;
        end else if (lat_note != 5'd0) begin
          if (match_any) begin
            do_zero  = 1'b1;
            zero_idx = match_idx;
            state_d  = S_GAP;
          end else if (free_any) begin
            do_write  = 1'b1;
            write_idx = free_idx;
          end else begin
            do_zero  = 1'b1;
            zero_idx = old_idx;
            steal_d  = 1'b1;
            state_d  = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt <= 4'd1) begin
          do_write = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      steal_pulse <= 1'b0;
      voice_busy  <= '0;
      lat_key_on  <= 1'b0;
      lat_note    <= 5'd0;
      lat_octave  <= 2'd0;
      gap_cnt     <= 4'd0;
      target      <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note[i]   <= 5'd0;
        octave[i] <= 2'd0;
        age[i]    <= 8'd0;
      end
    end else begin
      state       <= state_d;
      steal_pulse <= steal_d;
      voice_busy  <= busy_now;
      if (state == S_IDLE && ev_valid) begin
        lat_key_on <= ev_key_on;
        lat_note   <= ev_note;
        lat_octave <= ev_octave;
      end
      if (state == S_GAP) gap_cnt <= gap_cnt - 4'd1;
      if (do_zero) begin
        note[zero_idx] <= 5'd0;
        target         <= zero_idx;
        gap_cnt        <= 4'(STEAL_GAP);
      end
      if (do_clear_match) begin
        for (int i = 0; i < NUM_VOICES; i++)
          if (match[i]) note[i] <= 5'd0;
      end
      if (do_write) begin
        note[write_idx]   <= lat_note;
        octave[write_idx] <= lat_octave;
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (IW'(i) == write_idx)
            age[i] <= 8'd0;
          else if (busy_now[i] && age[i] != 8'd255)
            age[i] <= age[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    voice_note   = '0;
    voice_octave = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_note[5*i +: 5]   = note[i];
      voice_octave[2*i +: 2] = octave[i];
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - randomized and directed bench for voice_allocator
// against an event-level reference model of voice allocation.
module tb_voice_allocator;

  localparam int NV  = 4;
  localparam int GAP = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              ev_valid, ev_ready, ev_key_on;
  logic [4:0]        ev_note;
  logic [1:0]        ev_octave;
  logic [NV-1:0]     voice_done;
  logic [5*NV-1:0]   voice_note;
  logic [2*NV-1:0]   voice_octave;
  logic [NV-1:0]     voice_busy;
  logic              steal_pulse;

  voice_allocator #(.NUM_VOICES(NV), .STEAL_GAP(GAP)) dut (
    .clk(clk), .reset(reset), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_key_on(ev_key_on), .ev_note(ev_note), .ev_octave(ev_octave),
    .voice_done(voice_done), .voice_note(voice_note), .voice_octave(voice_octave),
    .voice_busy(voice_busy), .steal_pulse(steal_pulse)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int m_note [NV];
  int m_oct  [NV];
  int m_age  [NV];
  logic       p_kon;
  logic [4:0] p_note;
  logic [1:0] p_oct;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] get_note(input int i);
    return voice_note[5*i +: 5];
  endfunction

  function automatic logic [1:0] get_oct(input int i);
    return voice_octave[2*i +: 2];
  endfunction

  function automatic bit m_busy(input int i);
    return (m_note[i] != 0) || !voice_done[i];
  endfunction

  // Event-level outcome: latency in cycles of ev_ready low, target voice, steal flag.
  task automatic model_plan(output int lat, output int tgt, output int stl);
    lat = 1; tgt = -1; stl = 0;
    if (p_kon && p_note != 0) begin
      for (int i = NV - 1; i >= 0; i--)
        if (m_note[i] == p_note && m_oct[i] == p_oct) tgt = i;
      if (tgt >= 0) begin
        lat = 1 + GAP;
      end else begin
        for (int i = NV - 1; i >= 0; i--)
          if (m_note[i] == 0 && voice_done[i]) tgt = i;
        if (tgt < 0) begin
          int best = -1;
          for (int i = 0; i < NV; i++)
            if (m_busy(i) && (best < 0 || m_age[i] > best)) begin
              best = m_age[i];
              tgt  = i;
            end
          lat = 1 + GAP;
          stl = 1;
        end
      end
    end
  endtask

  task automatic model_apply(input int tgt);
    if (!p_kon) begin
      if (p_note != 0)
        for (int i = 0; i < NV; i++)
          if (m_note[i] == p_note && m_oct[i] == p_oct) m_note[i] = 0;
    end else if (tgt >= 0) begin
      m_note[tgt] = 0;
      for (int i = 0; i < NV; i++)
        if (i != tgt && m_busy(i) && m_age[i] < 255) m_age[i]++;
      m_age[tgt]  = 0;
      m_note[tgt] = p_note;
      m_oct[tgt]  = p_oct;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NV; i++) begin
      check($sformatf("note%0d", i), get_note(i), m_note[i]);
      check($sformatf("oct%0d", i), get_oct(i), m_oct[i]);
      check($sformatf("age%0d", i), dut.age[i], m_age[i]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ev_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NV; i++) begin
      m_note[i] = 0; m_oct[i] = 0; m_age[i] = 0;
    end
  endtask

  task automatic start_event(input logic kon, input logic [4:0] n, input logic [1:0] o);
    int w = 0;
    ev_valid = 1'b1; ev_key_on = kon; ev_note = n; ev_octave = o;
    while (!ev_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("accept_wait", (w < 100), 1);
    @(negedge clk);
    ev_valid = 1'b0;
    p_kon = kon; p_note = n; p_oct = o;
  endtask

  task automatic finish_event();
    int lat, tgt, stl, cyc, pulses, zeros;
    model_plan(lat, tgt, stl);
    check("ready_low_decide", ev_ready, 0);
    cyc = 0; pulses = 0; zeros = 0;
    while (!ev_ready && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (steal_pulse) pulses++;
      if (!ev_ready && lat > 1 && get_note(tgt) == 0) zeros++;
    end
    check("latency", cyc, lat);
    check("steal_pulses", pulses, stl);
    if (lat > 1) check("gap_zero_cycles", zeros, GAP);
    model_apply(tgt);
    compare_all();
  endtask

  task automatic run_event(input logic kon, input logic [4:0] n, input logic [1:0] o);
    start_event(kon, n, o);
    finish_event();
  endtask

  task automatic check_busy();
    @(negedge clk);
    for (int i = 0; i < NV; i++)
      check($sformatf("busy%0d", i), voice_busy[i], m_busy(i));
  endtask

  initial begin
    reset = 1'b1; ev_valid = 1'b0; ev_key_on = 1'b0; ev_note = 5'd0; ev_octave = 2'd0;
    voice_done = '1;
    @(negedge clk);
    do_reset();
    check("rst_ready", ev_ready, 1);
    check("rst_notes", voice_note, 0);
    check("rst_octaves", voice_octave, 0);
    check("rst_busy", voice_busy, 0);
    check("rst_steal", steal_pulse, 0);

    // Two free allocations
    run_event(1'b1, 5'd10, 2'd0);
    check("v0_note10", get_note(0), 10);
    run_event(1'b1, 5'd13, 2'd1);
    check("v1_note13", get_note(1), 13);
    check("v1_oct1", get_oct(1), 1);

    // Fill then steal voice 0
    do_reset();
    for (int k = 1; k <= 4; k++) run_event(1'b1, 5'(k), 2'd0);
    run_event(1'b1, 5'd5, 2'd0);
    check("steal_v0_note5", get_note(0), 5);
    check("steal_v0_age", dut.age[0], 0);

    // Retrigger on repeated key
    do_reset();
    run_event(1'b1, 5'd7, 2'd0);
    run_event(1'b1, 5'd7, 2'd0);
    check("retrig_v1_unused", get_note(1), 0);

    // Key-off with envelope still running
    do_reset();
    run_event(1'b1, 5'd7, 2'd0);
    voice_done[0] = 1'b0;
    run_event(1'b0, 5'd7, 2'd0);
    check_busy();
    check("keyoff_busy0", voice_busy[0], 1);
    run_event(1'b1, 5'd8, 2'd0);
    check("keyoff_v1_note8", get_note(1), 8);
    voice_done[0] = 1'b1;

    // Event held off while a steal gap runs, then reset during a gap
    do_reset();
    for (int k = 1; k <= 4; k++) run_event(1'b1, 5'(k), 2'd0);
    start_event(1'b1, 5'd5, 2'd0);
    ev_valid = 1'b1; ev_key_on = 1'b1; ev_note = 5'd6; ev_octave = 2'd1;
    finish_event();
    start_event(1'b1, 5'd6, 2'd1);
    finish_event();
    start_event(1'b1, 5'd6, 2'd1);
    @(negedge clk);
    check("gap_ready_low", ev_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_ready", ev_ready, 1);
    check("midrst_notes", voice_note, 0);
    check("midrst_octaves", voice_octave, 0);
    check("midrst_busy", voice_busy, 0);
    check("midrst_steal", steal_pulse, 0);
    for (int i = 0; i < NV; i++) begin
      m_note[i] = 0; m_oct[i] = 0; m_age[i] = 0;
    end
    compare_all();

    // Age saturation on a held voice, then it becomes the steal victim
    do_reset();
    run_event(1'b1, 5'd1, 2'd0);
    for (int k = 0; k < 300; k++) run_event(1'b1, 5'd2, 2'd0);
    check("sat_age0", dut.age[0], 255);
    run_event(1'b1, 5'd3, 2'd0);
    run_event(1'b1, 5'd4, 2'd0);
    check("sat_age0_hold", dut.age[0], 255);
    run_event(1'b1, 5'd9, 2'd2);
    check("sat_victim_v0", get_note(0), 9);

    // Randomized events against the model
    do_reset();
    for (int k = 0; k < 250; k++) begin
      for (int i = 0; i < NV; i++) voice_done[i] = ($urandom_range(0, 3) != 0);
      run_event(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 6)), 2'($urandom_range(0, 1)));
      check_busy();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice scheduler that sits between the keyboard/MIDI event decoder and a bank of NUM_VOICES oscillator instances. It accepts key-on/key-off events over a valid/ready handshake and assigns each key-on to a free voice by driving that voice's note/octave. When no voice is free, it steals the oldest voice, forcing a note-0 gap so the voice's envelope retriggers. Key-off clears the note of every voice holding that key, which starts that envelope's release.

## Interface
Parameters:
- NUM_VOICES, 4, number of oscillator voices managed (2..8)
- STEAL_GAP, 1, cycles a stolen/retriggered voice is held at note 0 before the new note is written (1..15)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ev_valid  in  1  event present
- ev_ready  out  1  allocator can accept an event this cycle
- ev_key_on  in  1  1 = key-on, 0 = key-off
- ev_note  in  5  note code (1..31; 0 = no note)
- ev_octave  in  2  octave shift
- voice_done  in  NUM_VOICES  per-voice envelope-finished flag from each oscillator
- voice_note  out  5*NUM_VOICES  per-voice note; voice i occupies bits [5i+4:5i]
- voice_octave  out  2*NUM_VOICES  per-voice octave; voice i occupies bits [2i+1:2i]
- voice_busy  out  NUM_VOICES  registered; bit i = voice i note != 0 or voice_done[i] == 0
- steal_pulse  out  1  one-cycle pulse when a sounding voice is reclaimed

## Operation
- Per-voice state: note (5 b), octave (2 b), age (8 b, saturating at 255).
- A voice is free when note == 0 and voice_done[i] == 1.
- A voice matches when its note == latched note (≠ 0) and its octave == latched octave.
- Free-voice selection: the lowest-index free voice. Oldest-voice selection: the voice with maximum age among voices with busy = 1; ties go to the lowest index.
- FSM states:
  - IDLE: ev_ready = 1. On ev_valid && ev_ready, latch key_on/note/octave and go to DECIDE.
  - DECIDE: ev_ready = 0. Decisions use registered voice state only.
    - Key-off: clear the note of all matching voices, then go to IDLE. Octave is retained. No match means no change.
    - Key-on with note 0: no change, go to IDLE.
    - Key-on where a voice matches: target is the lowest-index match. Set its note to 0, load the gap counter with STEAL_GAP, go to GAP. No steal_pulse.
    - Key-on with no match and a free voice: write the note and octave to the free voice, do the age update, go to IDLE.
    - Key-on with no match and no free voice: target is the oldest voice. Set its note to 0, pulse steal_pulse, load the gap counter, go to GAP.
  - GAP: decrement the counter. When it reaches 1, write the note and octave to the target, do the age update, and go to IDLE.
- Age update (on every note write):
  - Target age is set to 0.
  - Every other voice with busy = 1 gets age + 1, saturating at 255.
  - Free voices keep their age.

## Timing
- Reset values: all voice_note = 0, voice_octave = 0, ages = 0. State = IDLE, so ev_ready = 1 in the first cycle after reset deasserts. voice_busy = 0, steal_pulse = 0.
- Reset mid-operation: a latched event is discarded, no partial write occurs, and the FSM returns to IDLE.
- Free allocation: an event accepted at edge T shows its note on voice_note after edge T+1. ev_ready is high again in the cycle after T+1.
- Steal/retrigger:
  - The target note reads 0 after edge T+1 and stays 0 for exactly STEAL_GAP cycles.
  - The new note appears after edge T+1+STEAL_GAP.
  - steal_pulse is high in the cycle after edge T+1.
- Key-off: the affected notes read 0 after edge T+1.
- Throughput: one event per 2 cycles (free or key-off), or per 2+STEAL_GAP cycles (steal).
- voice_done changing in the same cycle as DECIDE is sampled as-is; no look-ahead.
- ev_ready is purely a function of state. ev_* inputs are ignored when ev_ready = 0.

## Test plan
- Reset, then key-on note 10 octave 0, then note 13 octave 1, with voice_done all 1 → voice0 = 10/0 and voice1 = 13/1, each 2 cycles after its accept. ev_ready drops for exactly 1 cycle per event.
- Fill all 4 voices with notes 1,2,3,4, then key-on note 5 → voice0 reads 0 for STEAL_GAP cycles, steal_pulse fires once, voice0 = 5, and voice0 age = 0 while voices 1–3 increment.
- Key-on note 7 twice → the second event retriggers the same voice (note 0 gap, then 7). No second voice is used and there is no steal_pulse.
- Key-off note 7 with that voice held at voice_done = 0 → note 0, voice_busy stays 1. A key-on note 8 arriving before voice_done rises goes to a different free voice.
- Key-on during GAP → ev_ready = 0 and the event is held. Assert reset during GAP → all outputs return to 0 and ev_ready = 1 on the next cycle.
- Run 300 allocations on one voice while another is held → the held voice's age saturates at 255 without wrapping, and the held voice is chosen as steal victim.
